// File: rtl/branch_resolve_unit_pkg.sv
// Shared types for the branch resolve unit: condition codes, FSM states and
// the condition-code width.
package branch_pkg;

  localparam int COND_W = 3;

  typedef enum logic [COND_W-1:0] {
    COND_NZ     = 3'd0,
    COND_EZ     = 3'd1,
    COND_LZ     = 3'd2,
    COND_GZ     = 3'd3,
    COND_LE     = 3'd4,
    COND_GE     = 3'd5,
    COND_ALWAYS = 3'd6,
    COND_NEVER  = 3'd7
  } br_cond_e;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FLAGS = 2'd1,
    RESOLVE    = 2'd2
  } br_state_e;

  // ALWAYS/NEVER never look at the flags, so they never wait for them.
  function automatic logic is_unconditional(input br_cond_e c);
    return (c == COND_ALWAYS) || (c == COND_NEVER);
  endfunction

endpackage

// File: rtl/branch_resolve_unit_cond_eval.sv
// Combinational condition evaluator: maps a condition code and the six ALU
// flags to a taken/not-taken decision.
module br_cond_eval
  import branch_pkg::*;
(
  input  br_cond_e cond,
  input  logic     nz,
  input  logic     ez,
  input  logic     lz,
  input  logic     gz,
  input  logic     le,
  input  logic     ge,
  output logic     taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_NZ:     taken = nz;
      COND_EZ:     taken = ez;
      COND_LZ:     taken = lz;
      COND_GZ:     taken = gz;
      COND_LE:     taken = le;
      COND_GE:     taken = ge;
      COND_ALWAYS: taken = 1'b1;
      default:     taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: waits for in-flight flag writes, resolves the branch and
// pulses a redirect to fetch. Define BRANCH_STATS_EN to add outcome/stall counters.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int PC_W   = 16,
  parameter int OFF_W  = 12,
  parameter int DATA_W = 36
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [COND_W-1:0] br_cond,
  input  logic [PC_W-1:0]   br_pc,
  input  logic [OFF_W-1:0]  br_offset,
  input  logic              br_link,
  input  logic              flag_pending,
  input  logic              flag_wr,
  input  logic              nz,
  input  logic              ez,
  input  logic              lz,
  input  logic              gz,
  input  logic              le,
  input  logic              ge,
  input  logic              flush,
  output logic              redirect_valid,
  output logic [PC_W-1:0]   redirect_pc,
  output logic              link_valid,
  output logic [DATA_W-1:0] link_addr,
  output br_state_e         state
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]       taken_cnt,
  output logic [31:0]       not_taken_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  br_cond_e         cond_q;
  logic [PC_W-1:0]  pc_q;
  logic [OFF_W-1:0] off_q;
  logic             link_q;
  logic             accept;
  logic             taken;
  logic [PC_W-1:0]  target;
  logic [PC_W-1:0]  pc_inc;

  // Handshake: a request transfers in a cycle where br_valid and br_ready are
  // both high; br_ready never depends on br_valid.
  assign br_ready = rst_n & ~flush & (state == IDLE);
  assign accept   = br_valid & br_ready;
  assign target   = pc_q + {{(PC_W-OFF_W){off_q[OFF_W-1]}}, off_q};
  assign pc_inc   = pc_q + PC_W'(1);

  br_cond_eval u_cond_eval (
    .cond  (cond_q),
    .nz    (nz),
    .ez    (ez),
    .lz    (lz),
    .gz    (gz),
    .le    (le),
    .ge    (ge),
    .taken (taken)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      cond_q         <= COND_NEVER;
      pc_q           <= '0;
      off_q          <= '0;
      link_q         <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      link_valid     <= 1'b0;
      link_addr      <= '0;
    end else begin
      redirect_valid <= 1'b0;
      link_valid     <= 1'b0;
      if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              cond_q <= br_cond_e'(br_cond);
              pc_q   <= br_pc;
              off_q  <= br_offset;
              link_q <= br_link;
              // A flag write landing this cycle makes the flags valid next cycle.
              if (!is_unconditional(br_cond_e'(br_cond)) && flag_pending && !flag_wr)
                state <= WAIT_FLAGS;
              else
                state <= RESOLVE;
            end
          end
          WAIT_FLAGS: begin
            if (flag_wr) state <= RESOLVE;
          end
          RESOLVE: begin
            state <= IDLE;
            if (taken) begin
              redirect_valid <= 1'b1;
              redirect_pc    <= target;
              link_valid     <= link_q;
              if (link_q) link_addr <= {{(DATA_W-PC_W){1'b0}}, pc_inc};
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      taken_cnt     <= '0;
      not_taken_cnt <= '0;
      stall_cnt     <= '0;
    end else begin
      if (state == RESOLVE && !flush) begin
        if (taken && taken_cnt != '1)          taken_cnt     <= taken_cnt + 32'd1;
        if (!taken && not_taken_cnt != '1)     not_taken_cnt <= not_taken_cnt + 32'd1;
      end
      if (state == WAIT_FLAGS && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed vector table, random
// vectors against a behavioural model, and hand-written flush/reset sequences.
module tb_branch_resolve_unit;
  import branch_pkg::*;

  localparam int PC_W   = 16;
  localparam int OFF_W  = 12;
  localparam int DATA_W = 36;

  logic              clk;
  logic              rst_n;
  logic              br_valid;
  logic              br_ready;
  logic [2:0]        br_cond;
  logic [PC_W-1:0]   br_pc;
  logic [OFF_W-1:0]  br_offset;
  logic              br_link;
  logic              flag_pending;
  logic              flag_wr;
  logic              nz, ez, lz, gz, le, ge;
  logic              flush;
  logic              redirect_valid;
  logic [PC_W-1:0]   redirect_pc;
  logic              link_valid;
  logic [DATA_W-1:0] link_addr;
  br_state_e         state;
`ifdef BRANCH_STATS_EN
  logic [31:0]       taken_cnt, not_taken_cnt, stall_cnt;
`endif

  branch_resolve_unit #(.PC_W(PC_W), .OFF_W(OFF_W), .DATA_W(DATA_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .br_valid       (br_valid),
    .br_ready       (br_ready),
    .br_cond        (br_cond),
    .br_pc          (br_pc),
    .br_offset      (br_offset),
    .br_link        (br_link),
    .flag_pending   (flag_pending),
    .flag_wr        (flag_wr),
    .nz             (nz),
    .ez             (ez),
    .lz             (lz),
    .gz             (gz),
    .le             (le),
    .ge             (ge),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .link_valid     (link_valid),
    .link_addr      (link_addr),
    .state          (state)
`ifdef BRANCH_STATS_EN
    ,
    .taken_cnt      (taken_cnt),
    .not_taken_cnt  (not_taken_cnt),
    .stall_cnt      (stall_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]       cond;
    logic [PC_W-1:0]  pc;
    logic [OFF_W-1:0] off;
    logic             link;
    logic [5:0]       flags;     // {ge, le, gz, lz, ez, nz}
    int               wait_n;    // 0 none, -1 flag_wr in accept cycle, n>0 flag_wr n cycles after accept
    int               flush_at;  // 0 none, else cycle after accept that carries flush
    logic             exp_taken;
    logic [PC_W-1:0]  exp_pc;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;
  logic [PC_W-1:0]   exp_q[$];
  logic [PC_W-1:0]   mdl_pc;
  logic [DATA_W-1:0] mdl_link;
  vec_t dir[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  // behavioural model
  function automatic logic model_taken(input logic [2:0] cond, input logic [5:0] flags);
    if (cond < 3'd6) return flags[cond];
    return cond == 3'd6;
  endfunction

  function automatic logic [PC_W-1:0] model_target(input logic [PC_W-1:0] pc, input logic [OFF_W-1:0] off);
    int o;
    o = int'(off);
    if (o >= 2048) o = o - 4096;
    return PC_W'(int'(pc) + o);
  endfunction

  function automatic int resolve_cycle(input vec_t v);
    return (v.cond < 3'd6 && v.wait_n > 0) ? v.wait_n + 1 : 1;
  endfunction

  function automatic vec_t mk(input logic [2:0] cond, input logic [15:0] pc, input logic [11:0] off,
                              input logic link, input logic [5:0] flags, input int wait_n,
                              input int flush_at, input logic exp_taken, input logic [15:0] exp_pc);
    vec_t v;
    v.cond = cond; v.pc = pc; v.off = off; v.link = link; v.flags = flags;
    v.wait_n = wait_n; v.flush_at = flush_at; v.exp_taken = exp_taken; v.exp_pc = exp_pc;
    return v;
  endfunction

  // driver tasks
  task automatic set_flags(input logic [5:0] f);
    {ge, le, gz, lz, ez, nz} = f;
  endtask

  task automatic drive_junk();
    br_cond   = 3'($urandom);
    br_pc     = PC_W'($urandom);
    br_offset = OFF_W'($urandom);
    br_link   = 1'($urandom);
  endtask

  task automatic apply_reset(input int cycles);
    @(posedge clk); #1;
    rst_n = 1'b0; br_valid = 1'b0; flush = 1'b0; flag_pending = 1'b0; flag_wr = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    check("rst_state", 64'(state), 64'(IDLE));
    check("rst_br_ready", 64'(br_ready), 64'd0);
    check("rst_redirect_valid", 64'(redirect_valid), 64'd0);
    check("rst_link_valid", 64'(link_valid), 64'd0);
    check("rst_redirect_pc", 64'(redirect_pc), 64'd0);
    check("rst_link_addr", 64'(link_addr), 64'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", 64'(br_ready), 64'd1);
    mdl_pc = '0; mdl_link = '0;
    exp_q.delete();
  endtask

  task automatic run_branch(input vec_t v);
    int   r;
    logic use_wait;
    logic fire;
    use_wait = (v.cond < 3'd6) && (v.wait_n > 0);
    r        = resolve_cycle(v);
    fire     = v.exp_taken && (v.flush_at == 0);
    if (fire) exp_q.push_back(v.exp_pc);
    @(posedge clk); #1;
    br_valid = 1'b1; br_cond = v.cond; br_pc = v.pc; br_offset = v.off; br_link = v.link;
    flag_pending = (v.wait_n != 0); flag_wr = (v.wait_n < 0); flush = 1'b0;
    set_flags(~v.flags);
    #1;
    check("pulse_cleared", 64'(redirect_valid | link_valid), 64'd0);
    check("accept_ready", 64'(br_ready), 64'd1);
    for (int c = 1; c <= r; c++) begin
      @(posedge clk); #1;
      br_valid = 1'b0;
      drive_junk();
      flag_wr      = use_wait && (c == v.wait_n);
      flag_pending = use_wait && (c <= v.wait_n);
      set_flags(c == r ? v.flags : ~v.flags);
      flush = (c == v.flush_at);
      #1;
      check("busy_ready", 64'(br_ready), 64'd0);
      check("busy_state", 64'(state), c == r ? 64'(RESOLVE) : 64'(WAIT_FLAGS));
      check("no_early_redirect", 64'(redirect_valid), 64'd0);
      if (c == v.flush_at) begin
        @(posedge clk); #1;
        flush = 1'b0; flag_pending = 1'b0; flag_wr = 1'b0;
        set_flags(~v.flags);
        #1;
        check("flush_state", 64'(state), 64'(IDLE));
        check("flush_no_redirect", 64'(redirect_valid | link_valid), 64'd0);
        check("flush_ready", 64'(br_ready), 64'd1);
        return;
      end
    end
    @(posedge clk); #1;
    set_flags(~v.flags);
    #1;
    check("done_state", 64'(state), 64'(IDLE));
    check("done_ready", 64'(br_ready), 64'd1);
    check("redirect_valid", 64'(redirect_valid), 64'(fire));
    check("link_valid", 64'(link_valid), 64'(fire & v.link));
    if (fire) begin
      check("redirect_pc", 64'(redirect_pc), 64'(exp_q.pop_front()));
      mdl_pc = v.exp_pc;
      if (v.link) begin
        mdl_link = DATA_W'(PC_W'(v.pc + 16'd1));
        check("link_addr", 64'(link_addr), 64'(mdl_link));
      end
    end else begin
      check("redirect_pc_hold", 64'(redirect_pc), 64'(mdl_pc));
      check("link_addr_hold", 64'(link_addr), 64'(mdl_link));
    end
  endtask

  initial begin
    vec_t v;
    rst_n = 1'b0; br_valid = 1'b0; flush = 1'b0; flag_pending = 1'b0; flag_wr = 1'b0;
    br_cond = '0; br_pc = '0; br_offset = '0; br_link = 1'b0;
    set_flags(6'b0);

    dir[0]  = mk(3'd1, 16'h0010, 12'h005, 1'b0, 6'b000010,  0, 0, 1'b1, 16'h0015);
    dir[1]  = mk(3'd2, 16'h0200, 12'h040, 1'b0, 6'b000100,  3, 0, 1'b1, 16'h0240);
    dir[2]  = mk(3'd6, 16'hFFFF, 12'h002, 1'b1, 6'b000000,  0, 0, 1'b1, 16'h0001);
    dir[3]  = mk(3'd0, 16'h0400, 12'h010, 1'b1, 6'b111110,  0, 0, 1'b0, 16'h0000);
    dir[4]  = mk(3'd7, 16'h0500, 12'h010, 1'b1, 6'b111111,  0, 0, 1'b0, 16'h0000);
    dir[5]  = mk(3'd5, 16'h0100, 12'hFFF, 1'b0, 6'b100000,  0, 0, 1'b1, 16'h00FF);
    dir[6]  = mk(3'd3, 16'h1234, 12'h800, 1'b1, 6'b001000, -1, 0, 1'b1, 16'h0A34);
    dir[7]  = mk(3'd4, 16'h0600, 12'h020, 1'b0, 6'b101111,  2, 0, 1'b0, 16'h0000);
    dir[8]  = mk(3'd6, 16'h0300, 12'h001, 1'b1, 6'b000000,  0, 1, 1'b1, 16'h0301);
    dir[9]  = mk(3'd1, 16'h0700, 12'h004, 1'b0, 6'b000010,  4, 2, 1'b1, 16'h0704);
    dir[10] = mk(3'd6, 16'h0050, 12'h7FF, 1'b0, 6'b000000,  3, 0, 1'b1, 16'h084F);

    apply_reset(3);

    for (int i = 0; i < 11; i++) run_branch(dir[i]);

    // reset in the middle of a flag wait clears outputs and state
    @(posedge clk); #1;
    br_valid = 1'b1; br_cond = 3'd1; br_pc = 16'h0800; br_offset = 12'h001; br_link = 1'b1;
    flag_pending = 1'b1; flag_wr = 1'b0;
    @(posedge clk); #1;
    br_valid = 1'b0;
    #1;
    check("mid_wait_state", 64'(state), 64'(WAIT_FLAGS));
    apply_reset(1);

    // flush has priority over accept
    @(posedge clk); #1;
    br_valid = 1'b1; br_cond = 3'd6; br_pc = 16'h0900; br_offset = 12'h003; flush = 1'b1;
    flag_pending = 1'b0;
    #1;
    check("flush_accept_ready", 64'(br_ready), 64'd0);
    @(posedge clk); #1;
    br_valid = 1'b0; flush = 1'b0;
    #1;
    check("flush_accept_state", 64'(state), 64'(IDLE));
    repeat (2) begin
      @(posedge clk); #1;
      check("flush_accept_no_redirect", 64'(redirect_valid), 64'd0);
    end

    // random vectors against the behavioural model
    for (int i = 0; i < 80; i++) begin
      v.cond  = 3'($urandom);
      v.pc    = PC_W'($urandom);
      v.off   = OFF_W'($urandom);
      v.link  = 1'($urandom);
      v.flags = 6'($urandom);
      case ($urandom_range(0, 4))
        0, 1:    v.wait_n = 0;
        2:       v.wait_n = -1;
        default: v.wait_n = int'($urandom_range(1, 3));
      endcase
      v.flush_at  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, resolve_cycle(v))) : 0;
      v.exp_taken = model_taken(v.cond, v.flags);
      v.exp_pc    = model_target(v.pc, v.off);
      run_branch(v);
    end

    @(posedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Consumes the registered condition flags (nz, ez, lz, gz, le, ge) produced by the scalar ALU compare ops.
- Resolves conditional branches: taken or not-taken, computes the target, and emits a one-cycle redirect to fetch.
- Stalls a branch until any in-flight flag-setting op has written its flags.
- Sits between decode/issue (producer, valid/ready) and fetch (redirect consumer).

Parameters:
- PC_W, 16, program counter width (instruction-word addressed).
- OFF_W, 12, branch offset width, two's complement.
- DATA_W, 36, width of link address output (scalar register width).

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, synchronous, active-low
- br_valid  input  1  branch request valid
- br_ready  output  1  unit can accept a request
- br_cond  input  3  condition code (see Behaviour)
- br_pc  input  PC_W  PC of branch instruction
- br_offset  input  OFF_W  signed target offset
- br_link  input  1  write return address if taken
- flag_pending  input  1  a flag-setting (op[3]=1) op is issued and has not yet passed its flag_wr cycle
- flag_wr  input  1  ALU flag registers update at the end of this cycle
- nz, ez, lz, gz, le, ge  input  1 each  current ALU flag registers
- flush  input  1  pipeline flush
- redirect_valid  output  1  one-cycle pulse: branch taken
- redirect_pc  output  PC_W  taken target
- link_valid  output  1  one-cycle pulse with redirect when br_link
- link_addr  output  DATA_W  br_pc+1, zero-extended

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE; br_ready, redirect_valid and link_valid are 0; redirect_pc and link_addr are 0.
  - br_ready=1 from the first cycle after reset deasserts.
- Condition codes:
  - 000 nz, 001 ez, 010 lz, 011 gz, 100 le, 101 ge.
  - 110 ALWAYS, 111 NEVER (reserved, resolves not-taken).
- States: IDLE, WAIT_FLAGS, RESOLVE.
- br_ready = (state==IDLE) & ~flush. The request is accepted on br_valid & br_ready; cond, pc, offset and link are latched.
- IDLE -> WAIT_FLAGS on accept when the cond is not ALWAYS/NEVER and flag_pending & ~flag_wr.
- IDLE -> RESOLVE on accept otherwise. If flag_wr is high in the accept cycle, the flags are valid next cycle, so no wait is needed.
- WAIT_FLAGS -> RESOLVE in the cycle flag_wr=1. Otherwise it holds, with no timeout.
- RESOLVE -> IDLE always:
  - Evaluates the latched cond against the flag inputs in that cycle.
  - If taken, registers redirect_valid=1, redirect_pc = br_pc + sext(br_offset) mod 2^PC_W (wraps), and link_valid=br_link.
- Latency: accept at cycle 0, RESOLVE at cycle 1, redirect visible at cycle 2 with no flag wait. Max throughput is one branch per 2 cycles.
- Not-taken: redirect_valid and link_valid stay 0. redirect_pc and link_addr hold their previous values.
- link_addr = {0, br_pc+1}. br_pc = all-ones wraps to 0.
- redirect_valid and link_valid are single-cycle pulses, cleared the cycle after.
- flush (any state):
  - Next state=IDLE and the latched branch is discarded.
  - A flush during RESOLVE suppresses the redirect.
  - Flush has priority over accept.
- Reset mid-operation: same as flush, plus output clear.
- Flags are sampled only in RESOLVE; flag changes in other cycles are ignored.

Optional Feature:
- Macro BRANCH_STATS_EN.
- Defined:
  - Adds outputs taken_cnt and not_taken_cnt (32-bit each), incremented in RESOLVE per outcome when not flushed.
  - Counters saturate at all-ones and reset to 0.
  - Adds stall_cnt (32-bit, saturating), incremented each cycle in WAIT_FLAGS.
- Undefined: none of these ports or registers exist.

Decomposition:
- Package branch_pkg holds:
  - enum br_cond_e for the 3-bit codes.
  - enum br_state_e.
  - constant COND_W=3.
- Sub-module br_cond_eval: combinational; inputs cond plus the six flags; output taken. Unit-testable alone.

Test Plan:
- No pending flags: cond=001, ez=1, pc=0x0010, off=+5 -> redirect_valid for 1 cycle at cycle 2, redirect_pc=0x0015.
- Flag wait: flag_pending=1 with flag_wr rising 3 cycles after accept, then lz=1 with cond=010 -> br_ready=0 throughout, redirect 2 cycles after flag_wr, target = pc+off.
- Wrap plus link: pc=0xFFFF, off=+2, cond=110, link=1 -> redirect_pc=0x0001, link_valid=1, link_addr=0x0_0000_0000 (zero-extended pc+1, wrapped).
- Not-taken and NEVER: cond=000 with nz=0, then cond=111 -> no redirect_valid or link_valid; br_ready back to 1 after 2 cycles each.
- Flush in RESOLVE and in WAIT_FLAGS -> no redirect, state IDLE next cycle; a new request accepted the cycle after flush deasserts.
- Negative offset: pc=0x0100, off=0xFFF (-1), cond=101, ge=1 -> redirect_pc=0x00FF.
